cam_pattern_gen: RTL and testbench
==================================

CAM_PATTERN_GEN -- requirements
Module: cam_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 320, active pixels per line; each pixel takes two byte clocks.
REQ-002 Parameter V_ACTIVE, default 240, active lines per frame.
REQ-003 Parameter H_BLANK, default 144, clocks per line with href low after the active bytes.
REQ-004 Parameter VS_LINES / VB_LINES / VF_LINES, defaults 3 / 17 / 10: vsync lines, back-porch lines and front-porch lines.
REQ-005 Port list (name, direction, width, meaning):
- clk, in, 1: pixel-byte clock; it also drives the consumer's pclk.
- reset, in, 1: asynchronous, active-low.
- enable, in, 1: run frames.
- mode, in, 2: pattern select.
- fg_color, in, 12: RGB444 foreground colour.
- bg_color, in, 12: RGB444 background colour.
- rect_x0, in, 9: rectangle left edge, inclusive.
- rect_x1, in, 9: rectangle right edge, inclusive.
- rect_y0, in, 9: rectangle top edge, inclusive.
- rect_y1, in, 9: rectangle bottom edge, inclusive.
- vsync, out, 1: camera vsync, active high.
- href, out, 1: line-valid.
- data, out, 8: pixel byte.
- busy, out, 1: a frame is in progress.
- frame_done, out, 1: one-cycle pulse at the end of a frame.
- frame_cnt, out, 8: completed frames.

Function
REQ-006 Line timing: every line has length L = 2*H_ACTIVE + H_BLANK clocks, counted by a column counter 0..L-1 that wraps to 0.
REQ-007 FSM states and transitions:
- IDLE -> VSYNC when enable=1.
- VSYNC (VS_LINES lines) -> VBACK (VB_LINES) -> ACTIVE (V_ACTIVE) -> VFRONT (VF_LINES).
- VFRONT -> VSYNC if enable=1 at the last clock of VFRONT, else -> IDLE.
REQ-008 vsync shall be 1 exactly during VSYNC lines; href shall be 0 outside ACTIVE.
REQ-009 In ACTIVE, href shall be 1 for columns 0..2*H_ACTIVE-1 and 0 for the blank columns.
REQ-010 Pixel coordinates: x = column>>1, y = active line index (0-based).
REQ-011 Byte order per pixel: the even column sends {4'b0000, R}; the odd column sends {G, B}.
REQ-012 data shall be 8'h00 whenever href=0.
REQ-013 vsync, href and data shall be registered outputs that change together on the same clock edge; there is no combinational path from inputs to outputs.
REQ-014 Pattern colour c(x,y) by mode:
- 0: fg_color.
- 1: gradient {x[3:0], y[3:0], x[7:4]}.
- 2: fg_color when rect_x0<=x<=rect_x1 and rect_y0<=y<=rect_y1, else bg_color.
- 3: checker, fg_color when x[3]^y[3]^frame_cnt[0] is 1, else bg_color.
REQ-015 The rectangle is empty (all bg_color) when rect_x0>rect_x1 or rect_y0>rect_y1; edges beyond H_ACTIVE-1 or V_ACTIVE-1 are clipped.
REQ-016 mode, fg_color, bg_color and rect_* shall be sampled once on entry to VSYNC and held for the whole frame; changes mid-frame take effect only in the next frame.
REQ-017 enable deasserted mid-frame shall not truncate the frame; the frame completes through VFRONT.
REQ-018 busy shall be 1 in every state except IDLE.
REQ-019 frame_done shall pulse for exactly one clock on the last clock of VFRONT.
REQ-020 frame_cnt shall increment on that same cycle and wrap 255 -> 0.
REQ-021 Frame length in clocks shall be exactly (VS_LINES + VB_LINES + V_ACTIVE + VF_LINES) * L.
REQ-022 Back-to-back frames (enable held at 1) shall have no idle gap: the first VSYNC clock immediately follows the last VFRONT clock.
REQ-023 Leaving IDLE: the first VSYNC=1 output appears on the clock after enable is first sampled at 1.

Reset
REQ-024 While reset=0, regardless of clk: state=IDLE, counters=0, vsync=0, href=0, data=8'h00, busy=0, frame_done=0, frame_cnt=0, and the sampled configuration is cleared.
REQ-025 Reset asserted mid-frame shall abort the frame immediately with no frame_done pulse.
REQ-026 After reset is released, no frame starts until enable is sampled at 1 on a clk edge.

Verification
Bench parameters: H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, VS_LINES=VB_LINES=VF_LINES=1, so L=10 and a frame is 60 clocks.
REQ-027 Timing: enable=1 held -> vsync high for 10 clocks; href absent for 10 clocks; 3 lines of 8 href clocks plus 2 blank; 10 front-porch clocks; frame_done every 60 clocks; frame_cnt 1,2,3.
REQ-028 Mode 0, fg_color=12'hABC -> data sequence 0A,BC repeated 4 times per line; data=00 during blanking.
REQ-029 Mode 2, rect x1..2, y1..1, fg=12'hF00, bg=12'h00F -> line 1 pixels bg,fg,fg,bg; lines 0 and 2 all bg.
REQ-030 Mode 2 with rect_x0=3, rect_x1=1 -> all pixels bg_color.
REQ-031 Config and enable mid-frame: change mode from 0 to 1 during ACTIVE -> current frame stays mode 0 and the next frame is gradient; drop enable in VBACK -> the frame completes, frame_done pulses, then busy=0.
REQ-032 Reset mid-frame: reset low during ACTIVE line 1 -> outputs zero immediately, no frame_done, frame_cnt=0; enable=1 after release -> a full 60-clock frame follows.

Source files
------------

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: camera-style vsync/href/data frame generator with selectable test patterns.
module cam_pattern_gen #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int VB_LINES = 17,
  parameter int VF_LINES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] fg_color,
  input  logic [11:0] bg_color,
  input  logic [8:0]  rect_x0,
  input  logic [8:0]  rect_x1,
  input  logic [8:0]  rect_y0,
  input  logic [8:0]  rect_y1,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);
  localparam int L  = 2 * H_ACTIVE + H_BLANK;
  localparam int CW = $clog2(L);
  localparam int LW = $clog2(VS_LINES + VB_LINES + V_ACTIVE + VF_LINES + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(L - 1);
  localparam logic [CW-1:0] HREF_END = CW'(2 * H_ACTIVE);
  localparam logic [LW-1:0] VF_LAST  = LW'(VF_LINES - 1);
  localparam logic [2:0] IDLE = 3'd0, VSYNC = 3'd1, VBACK = 3'd2, ACTIVE = 3'd3, VFRONT = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] line_q, line_d, line_last;
  logic [61:0]   cfg_q, cfg_d;
  logic          vsync_q, vsync_d, href_q, href_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic [7:0]    data_q, data_d, frame_cnt_q, frame_cnt_d;
  logic          eol, eos, in_rect;
  logic [8:0]    x, y;
  logic [11:0]   pix;
  logic [1:0]    c_mode;
  logic [11:0]   c_fg, c_bg;
  logic [8:0]    c_x0, c_x1, c_y0, c_y1;
  assign {c_mode, c_fg, c_bg, c_x0, c_x1, c_y0, c_y1} = cfg_q;
  assign line_last = state_q == VSYNC  ? LW'(VS_LINES - 1) :
                     state_q == VBACK  ? LW'(VB_LINES - 1) :
                     state_q == ACTIVE ? LW'(V_ACTIVE - 1) : VF_LAST;
  assign eol = col_q == COL_LAST;
  assign eos = eol && line_q == line_last;
  // Outputs are registered from the next position so they line up with the state on the same edge.
  always_comb begin
    col_d   = (state_q == IDLE || eol) ? '0 : col_q + 1'b1;
    line_d  = (state_q == IDLE || eos) ? '0 : line_q + LW'(eol);
    state_d = state_q == IDLE   ? (enable ? VSYNC : IDLE) :
              !eos              ? state_q :
              state_q == VSYNC  ? VBACK :
              state_q == VBACK  ? ACTIVE :
              state_q == ACTIVE ? VFRONT : (enable ? VSYNC : IDLE);
    cfg_d   = (state_d == VSYNC && state_q != VSYNC) ?
              {mode, fg_color, bg_color, rect_x0, rect_x1, rect_y0, rect_y1} : cfg_q;
    x       = 9'(col_d >> 1);
    y       = 9'(line_d);
    in_rect = x >= c_x0 && x <= c_x1 && y >= c_y0 && y <= c_y1;
    pix     = c_mode == 2'd0 ? c_fg :
              c_mode == 2'd1 ? {x[3:0], y[3:0], x[7:4]} :
              c_mode == 2'd2 ? (in_rect ? c_fg : c_bg) :
              ((x[3] ^ y[3] ^ frame_cnt_q[0]) ? c_fg : c_bg);
    href_d       = state_d == ACTIVE && col_d < HREF_END;
    data_d       = href_d ? (col_d[0] ? pix[7:0] : {4'h0, pix[11:8]}) : 8'h00;
    vsync_d      = state_d == VSYNC;
    busy_d       = state_d != IDLE;
    frame_done_d = state_d == VFRONT && col_d == COL_LAST && line_d == VF_LAST;
    frame_cnt_d  = frame_cnt_q + 8'(frame_done_d);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      line_q       <= '0;
      cfg_q        <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      cfg_q        <= cfg_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb_cam_pattern_gen: randomized frames checked every cycle against a frame-position model.
module tb_cam_pattern_gen;
  localparam int HA = 4, VA = 3, HB = 2, VS = 1, VB = 1, VF = 1;
  localparam int L = 2 * HA + HB, FL = (VS + VB + VA + VF) * L;
  logic clk = 0, reset = 0, enable = 0;
  logic [1:0] mode = 0;
  logic [11:0] fg = 0, bg = 0;
  logic [8:0] rx0 = 0, rx1 = 0, ry0 = 0, ry1 = 0;
  logic vsync, href, busy, frame_done;
  logic [7:0] data, frame_cnt;
  int errors = 0, checks = 0;
  int poke_at = 0;
  logic [1:0] poke_mode = 0;
  logic poke_en = 1;
  logic [11:0] poke_fg = 0;
  cam_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                    .VS_LINES(VS), .VB_LINES(VB), .VF_LINES(VF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .fg_color(fg), .bg_color(bg),
    .rect_x0(rx0), .rect_x1(rx1), .rect_y0(ry0), .rect_y1(ry1),
    .vsync(vsync), .href(href), .data(data), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: frame position pos (-1 = idle), frame counter and the configuration latched at frame start.
  int pos = -1;
  logic [7:0] mcnt = 0;
  logic [1:0] mm = 0;
  logic [11:0] mfg = 0, mbg = 0;
  int mx0 = 0, mx1 = 0, my0 = 0, my1 = 0;
  logic e_vs = 0, e_href = 0, e_busy = 0, e_done = 0;
  logic [7:0] e_data = 0, e_cnt = 0;
  always @(posedge clk) begin
    int ln, cl, x, y;
    logic act, on;
    logic [11:0] c;
    if (!reset) begin
      pos = -1;
      mcnt = 0;
    end else begin
      if (pos < 0 || pos == FL - 1) begin
        if (enable) begin
          pos = 0;
          mm = mode; mfg = fg; mbg = bg;
          mx0 = rx0; mx1 = rx1; my0 = ry0; my1 = ry1;
        end else pos = -1;
      end else pos++;
      if (pos == FL - 1) mcnt++;
    end
    ln = pos / L;
    cl = pos % L;
    x = cl / 2;
    y = ln - VS - VB;
    act = pos >= 0 && ln >= VS + VB && ln < VS + VB + VA;
    on = 0;
    c = 0;
    if (mm == 0) c = mfg;
    else if (mm == 1) c = {4'(x % 16), 4'(y % 16), 4'((x / 16) % 16)};
    else begin
      on = (mm == 2) ? (x >= mx0 && x <= mx1 && y >= my0 && y <= my1)
                     : (((x / 8) + (y / 8) + int'(mcnt)) % 2 == 1);
      c = on ? mfg : mbg;
    end
    e_busy = pos >= 0;
    e_vs = pos >= 0 && pos < VS * L;
    e_href = act && cl < 2 * HA;
    e_data = e_href ? ((cl % 2 == 1) ? c[7:0] : {4'h0, c[11:8]}) : 8'h00;
    e_done = pos == FL - 1;
    e_cnt = mcnt;
  end
  always @(posedge clk) begin
    #1;
    chk("vsync", vsync, e_vs);
    chk("href", href, e_href);
    chk("data", data, e_data);
    chk("busy", busy, e_busy);
    chk("frame_done", frame_done, e_done);
    chk("frame_cnt", frame_cnt, e_cnt);
  end
  task automatic frame(output int len, output int vs, output int hr, output logic [7:0] b0, output logic [7:0] b1);
    int n;
    bit got;
    n = 0; got = 0; len = 0; vs = 0; hr = 0; b0 = 0; b1 = 0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clk);
      vs += int'(vsync);
      hr += int'(href);
      if (href) begin
        if (n == 0) b0 = data;
        if (n == 1) b1 = data;
        n++;
      end
      if (frame_done) begin
        len = i;
        got = 1;
      end
      if (i == poke_at) begin
        mode = poke_mode;
        enable = poke_en;
        fg = poke_fg;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL frame_timeout: no frame_done within 200 clocks");
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("idle_reached", busy, 0);
  endtask
  int len, vs, hr, exp_cnt;
  logic [7:0] b0, b1;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vsync", vsync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", frame_cnt, 0);
    reset = 1;
    repeat (4) @(negedge clk);
    chk("idle_no_start", busy, 0);
    mode = 0; fg = 12'hABC; bg = 12'h123; enable = 1;
    poke_at = 0; poke_en = 1; poke_mode = 0; poke_fg = 12'hABC;
    for (int k = 1; k <= 3; k++) begin
      frame(len, vs, hr, b0, b1);
      chk("len", len, 60);
      chk("vs_clocks", vs, 10);
      chk("href_clocks", hr, 24);
      chk("byte0", b0, 8'h0A);
      chk("byte1", b1, 8'hBC);
      chk("cnt", frame_cnt, k);
    end
    poke_at = 25; poke_mode = 1; poke_fg = 12'h555;
    frame(len, vs, hr, b0, b1);
    chk("midchg_byte0", b0, 8'h0A);
    chk("midchg_byte1", b1, 8'hBC);
    poke_at = 15; poke_en = 0; poke_fg = 12'h555;
    frame(len, vs, hr, b0, b1);
    chk("grad_len", len, 60);
    chk("grad_byte1", b1, 8'h00);
    @(negedge clk);
    chk("drop_en_idle", busy, 0);
    chk("cnt5", frame_cnt, 5);
    mode = 2; fg = 12'hF00; bg = 12'h00F; rx0 = 1; rx1 = 2; ry0 = 1; ry1 = 1;
    poke_mode = 2; poke_fg = 12'hF00; enable = 1;
    frame(len, vs, hr, b0, b1);
    chk("rect_byte0", b0, 8'h00);
    chk("rect_byte1", b1, 8'h0F);
    @(negedge clk);
    chk("rect_idle", busy, 0);
    rx0 = 3; rx1 = 1; ry0 = 0; ry1 = 2; enable = 1;
    frame(len, vs, hr, b0, b1);
    chk("empty_len", len, 60);
    exp_cnt = 7;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mode = 2'($urandom_range(0, 3));
      fg = 12'($urandom); bg = 12'($urandom);
      rx0 = 9'($urandom_range(0, 5)); rx1 = 9'($urandom_range(0, 5));
      ry0 = 9'($urandom_range(0, 4)); ry1 = 9'($urandom_range(0, 4));
      enable = 1;
      poke_at = $urandom_range(2, 58);
      poke_mode = 2'($urandom_range(0, 3));
      poke_en = 1'($urandom_range(0, 1));
      poke_fg = 12'($urandom);
      frame(len, vs, hr, b0, b1);
      exp_cnt++;
      chk("rand_len_max", int'(len <= 61), 1);
      chk("rand_cnt", frame_cnt, exp_cnt);
    end
    poke_at = 0; enable = 0;
    wait_idle();
    mode = 0; fg = 12'hABC; enable = 1;
    repeat (35) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    reset = 0;
    #1;
    chk("arst_vsync", vsync, 0);
    chk("arst_href", href, 0);
    chk("arst_data", data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_cnt", frame_cnt, 0);
    repeat (3) @(negedge clk);
    reset = 1; enable = 1; poke_en = 1; poke_fg = 12'hABC; poke_mode = 0;
    frame(len, vs, hr, b0, b1);
    chk("post_rst_len", len, 60);
    chk("post_rst_cnt", frame_cnt, 1);
    enable = 0;
    repeat (70) @(negedge clk);
    chk("final_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
